vga_scan_gen: RTL and testbench

Raster timing generator and output stage for the 640x480@60 Hz VGA display. Produces the DrawX/DrawY scan coordinates consumed by the colour mapper and sprite logic, takes the mapper's combinational RGB back, and drives the registered VGA DAC pins (RGB, syncs, blank, pixel clock). It also produces a once-per-frame pulse for game-state update logic. Runs from the 50 MHz system clock with an internal divide-by-2 pixel enable.

---
 rtl/vga_scan_gen.sv | 110 +++++++++++
 tb/tb_vga_scan_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// 640x480@60 VGA raster generator: divide-by-2 pixel enable, scan counters,
// and a registered DAC output stage one pixel behind DrawX/DrawY.

module vga_dac_lane (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       en,
  input  logic       visible,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  always_ff @(posedge Clk) begin
    if (Reset)   dout <= 8'h00;
    else if (en) dout <= visible ? din : 8'h00;
  end
endmodule

module vga_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_clk,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);
  localparam int NUM_CH = 3;

  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] V_VLAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pe;
  logic [9:0] h_cnt, v_cnt;
  logic       visible;

  logic [NUM_CH-1:0][7:0] rgb_in, rgb_out;

  assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pe          <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      frame_clk   <= 1'b0;
    end else begin
      pe <= ~pe;
      // Registered one cycle ahead so the pulse lines up with DrawY reaching V_VISIBLE.
      frame_clk <= pe && (h_cnt == H_LAST) && (v_cnt == V_VLAST);
      if (pe) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
        VGA_HS      <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        VGA_VS      <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        VGA_BLANK_N <= visible;
      end
    end
  end

  assign rgb_in = {R_in, G_in, B_in};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    vga_dac_lane u_lane (
      .Clk     (Clk),
      .Reset   (Reset),
      .en      (pe),
      .visible (visible),
      .din     (rgb_in[c]),
      .dout    (rgb_out[c])
    );
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_out;
  assign DrawX      = h_cnt;
  assign DrawY      = v_cnt;
  assign VGA_CLK    = pe;
  assign VGA_SYNC_N = 1'b0;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a shrunken-raster instance checked cycle by cycle
// against a scoreboard, plus a default 640x480 instance checked over one line.

module tb_vga_scan_gen;
  // Scaled-down raster so two full frames stay short.
  localparam int HV = 16, HF = 4, HSW = 6, HB = 4, HT = HV + HF + HSW + HB;
  localparam int VV = 12, VF = 2, VSW = 2, VB = 3, VT = VV + VF + VSW + VB;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] R_in = '0, G_in = '0, B_in = '0;

  logic [9:0] s_x, s_y, f_x, f_y;
  logic       s_fc, s_clk, s_hs, s_vs, s_bn, s_sn;
  logic       f_fc, f_clk, f_hs, f_vs, f_bn, f_sn;
  logic [7:0] s_r, s_g, s_b, f_r, f_g, f_b;

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) u_small (
    .Clk(Clk), .Reset(Reset), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .DrawX(s_x), .DrawY(s_y), .frame_clk(s_fc), .VGA_CLK(s_clk),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  vga_scan_gen u_full (
    .Clk(Clk), .Reset(Reset), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .DrawX(f_x), .DrawY(f_y), .frame_clk(f_fc), .VGA_CLK(f_clk),
    .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANK_N(f_bn), .VGA_SYNC_N(f_sn),
    .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bn;
    logic [23:0] rgb;
  } out_t;

  localparam out_t RST_OUT = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, rgb: 24'h0};

  out_t q[$];
  int   tests = 0, fails = 0;
  int   m_x = 0, m_y = 0;
  logic m_pe = 1'b0;
  logic exp_fc = 1'b0;
  int   cyc_n = 0;

  logic fstat_en = 1'b0;
  int   f_hs_low = 0, f_bn_hi = 0, f_rgb_hi = 0, t656 = -1, thsl = -1;
  int   f_wraps = 0, f_wrap_y = -1;
  logic [9:0] f_px = '0;
  int   s_vs_low = 0, s_fc_cnt = 0;
  int   fc_t[$];

  function automatic out_t exp_out(int x, int y, logic [23:0] rgb);
    out_t o;
    logic vis;
    vis   = (x < HV) && (y < VV);
    o.hs  = !(x >= HV + HF && x < HV + HF + HSW);
    o.vs  = !(y >= VV + VF && y < VV + VF + VSW);
    o.bn  = vis;
    o.rgb = vis ? rgb : 24'h0;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  // One Clk cycle: drive at negedge, advance the reference at posedge, check at next negedge.
  task automatic cyc(input logic rst, input logic rnd);
    logic pe_old;
    int   x_old, y_old;
    out_t e;
    Reset = rst;
    if (!rst && !m_pe) begin
      {R_in, G_in, B_in} = rnd ? 24'($urandom) : 24'hABCDEF;
      q.push_back(exp_out(m_x, m_y, {R_in, G_in, B_in}));
    end
    @(posedge Clk);
    pe_old = m_pe; x_old = m_x; y_old = m_y;
    if (rst) begin
      m_pe = 1'b0; m_x = 0; m_y = 0;
      q.delete();
    end else begin
      if (m_pe) begin
        if (m_x == HT - 1) begin
          m_x = 0;
          m_y = (m_y == VT - 1) ? 0 : m_y + 1;
        end else m_x++;
      end
      m_pe = !m_pe;
    end
    exp_fc = !rst && pe_old && x_old == HT - 1 && y_old == VV - 1;
    @(negedge Clk);
    cyc_n++;
    chk("drawx", 32'(s_x), 32'(m_x));
    chk("drawy", 32'(s_y), 32'(m_y));
    chk("vga_clk", 32'(s_clk), 32'(m_pe));
    chk("frame_clk", 32'(s_fc), 32'(exp_fc));
    chk("sync_n", 32'(s_sn), 32'(f_sn));
    if (rst) begin
      chk("rst_out", 32'({s_hs, s_vs, s_bn, s_r, s_g, s_b}), 32'(RST_OUT));
      chk("full_rst_out", 32'({f_hs, f_vs, f_bn, f_r, f_g, f_b, f_fc, f_clk}),
          32'({RST_OUT, 2'b00}));
      chk("full_rst_xy", 32'({f_x, f_y}), 32'(0));
    end else if (pe_old) begin
      chk("sb_depth", 32'(q.size()), 32'(1));
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dac_out", 32'({s_hs, s_vs, s_bn, s_r, s_g, s_b}), 32'(e));
      end
    end
    s_vs_low += int'(!s_vs);
    s_fc_cnt += int'(s_fc);
    if (s_fc) fc_t.push_back(cyc_n);
    if (fstat_en) begin
      if (cyc_n < 50) chk("full_drawx", 32'(f_x), 32'(m_x));
      f_hs_low += int'(!f_hs);
      f_bn_hi  += int'(f_bn);
      if (f_bn && {f_r, f_g, f_b} == 24'hABCDEF) f_rgb_hi++;
      if (f_x == 10'd656 && t656 < 0) t656 = cyc_n;
      if (!f_hs && thsl < 0) thsl = cyc_n;
      if (f_px == 10'd799 && f_x == 10'd0) begin
        f_wraps++;
        f_wrap_y = int'(f_y);
      end
      f_px = f_x;
    end
  endtask

  initial begin
    int n;
    // Reset hold.
    repeat (5) cyc(1'b1, 1'b0);
    chk("sync_n_tied", 32'(s_sn), 32'(0));

    // Free run, constant colour: two small frames, one full line.
    cyc_n = 0;
    s_vs_low = 0; s_fc_cnt = 0;
    fstat_en = 1'b1;
    for (int i = 0; i < 2 * HT * VT * 2 + 20; i++) begin
      if (cyc_n == 1600) fstat_en = 1'b0;
      cyc(1'b0, 1'b0);
    end
    chk("full_hs_low_clk", 32'(f_hs_low), 32'(192));
    chk("full_hs_delay", 32'(thsl - t656), 32'(2));
    chk("full_blank_hi_clk", 32'(f_bn_hi), 32'(1280));
    chk("full_rgb_when_vis", 32'(f_rgb_hi), 32'(1280));
    chk("full_wraps", 32'(f_wraps), 32'(1));
    chk("full_wrap_y", 32'(f_wrap_y), 32'(1));
    chk("vs_low_clk", 32'(s_vs_low), 32'(2 * VSW * HT * 2));
    chk("frame_pulses", 32'(s_fc_cnt), 32'(2));
    if (fc_t.size() >= 2) chk("frame_period", 32'(fc_t[1] - fc_t[0]), 32'(HT * VT * 2));

    // Reset mid-frame, then restart with random colour.
    n = 0;
    while (!(m_x == 10 && m_y == 5) && n < 3000) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    chk("reach_mid_frame", 32'(n < 3000), 32'(1));
    s_fc_cnt = 0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < HT * VT * 2 + 40; i++) cyc(1'b0, 1'b1);
    chk("frame_pulses_after_rst", 32'(s_fc_cnt), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
